race_frame_ctrl: RTL and testbench

Frame-level sequencer for the racer video pipeline. It watches the timing generator's vertical blanking and runs the game state machine: idle, countdown, race and finish. Per frame it produces the vertical scroll offset, countdown digit and layer enables consumed by the background and overlay drawing stages. It owns the speed register and accepts speed updates from game logic through a req/ack handshake. All updates are frame-synchronous, applied only at the start of vertical blanking.

---
 rtl/racer_pkg.sv | 37 +++
 rtl/speed_handshake.sv | 59 +++++
 rtl/race_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_race_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/racer_pkg.sv
// Shared types and widths for the racer frame sequencer: state encoding,
// overlay layer bit positions and the per-state layer mask.
package racer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_FINISH    = 2'd3
    } race_state_t;

    localparam int LAYER_BG    = 0;
    localparam int LAYER_TRACK = 1;
    localparam int LAYER_TEXT  = 2;

    localparam int VCOUNT_W = 11;
    localparam int SPEED_W  = 4;
    localparam int DIST_W   = 16;

    function automatic logic [2:0] layer_for(input race_state_t s);
        logic [2:0] l;
        l = '0;
        case (s)
            ST_IDLE: begin
                l[LAYER_BG]   = 1'b1;
                l[LAYER_TEXT] = 1'b1;
            end
            ST_RACE: begin
                l[LAYER_BG]    = 1'b1;
                l[LAYER_TRACK] = 1'b1;
            end
            default: l = 3'b111;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/speed_handshake.sv
// Speed update req/ack capture with saturation into a shadow register, plus the
// crash latch; a pending crash masks any pending speed so the crash wins the tick.
module speed_handshake
    import racer_pkg::*;
#(
    parameter int MAX_SPEED = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               in_race,
    input  logic               speed_req,
    input  logic [SPEED_W-1:0] speed_val,
    input  logic               crash_in,
    output logic               speed_ack,
    output logic [SPEED_W-1:0] spd_pend,
    output logic               pend_valid,
    output logic               crash_pending
);

    localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(MAX_SPEED);

    logic               ack_reg;
    logic               valid_reg;
    logic               crash_reg;
    logic [SPEED_W-1:0] pend_reg;
    logic [SPEED_W-1:0] spd_sat;

    assign spd_sat = (speed_val > SPD_MAX) ? SPD_MAX : speed_val;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_reg   <= 1'b0;
            valid_reg <= 1'b0;
            crash_reg <= 1'b0;
            pend_reg  <= '0;
        end else begin
            ack_reg <= speed_req && !ack_reg;
            if (tick) begin
                valid_reg <= 1'b0;
                crash_reg <= 1'b0;
            end
            // A capture or crash landing on the tick cycle itself waits for the next frame.
            if (speed_req && !ack_reg) begin
                pend_reg  <= spd_sat;
                valid_reg <= 1'b1;
            end
            if (crash_in && in_race) begin
                crash_reg <= 1'b1;
            end
        end
    end

    assign speed_ack     = ack_reg;
    assign spd_pend      = pend_reg;
    assign pend_valid    = valid_reg && !crash_reg;
    assign crash_pending = crash_reg;

endmodule

// File: rtl/race_frame_ctrl.sv
// Frame-level game sequencer: vblank edge detect, idle/countdown/race/finish FSM,
// scroll offset and distance tracking, all updated once per frame.
module race_frame_ctrl
    import racer_pkg::*;
#(
    parameter int V_ACTIVE         = 768,
    parameter int COUNTDOWN_FRAMES = 60,
    parameter int TRACK_LEN        = 4096,
    parameter int FINISH_FRAMES    = 180,
    parameter int MAX_SPEED        = 15
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start_btn,
    input  logic        crash_in,
    input  logic        speed_req,
    input  logic [3:0]  speed_val,
    output logic        speed_ack,
    output logic        frame_tick,
    output logic [1:0]  state,
    output logic [1:0]  digit,
    output logic [10:0] scroll_y,
    output logic [2:0]  layer_en,
    output logic        race_done
);

    localparam int CNT_MAX = (COUNTDOWN_FRAMES > FINISH_FRAMES) ? COUNTDOWN_FRAMES : FINISH_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]    CD_LAST   = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0]    FIN_LAST  = CNT_W'(FINISH_FRAMES - 1);
    localparam logic [VCOUNT_W:0]   V_WRAP    = (VCOUNT_W + 1)'(V_ACTIVE);
    localparam logic [DIST_W-1:0]   TRACK_END = DIST_W'(TRACK_LEN);

    race_state_t         state_reg;
    logic                vblnk_d_reg;
    logic                tick_reg;
    logic [1:0]          digit_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [VCOUNT_W-1:0] scroll_reg;
    logic [DIST_W-1:0]   dist_reg;
    logic [SPEED_W-1:0]  speed_reg;
    logic                start_pending_reg;
    logic [2:0]          layer_reg;
    logic                done_reg;

    logic                tick_now;
    logic                in_race;
    logic [SPEED_W-1:0]  spd_pend;
    logic                pend_valid;
    logic                crash_pending;
    logic [VCOUNT_W:0]   scroll_sum;
    logic [VCOUNT_W-1:0] scroll_next;
    logic [DIST_W:0]     dist_sum;
    logic [DIST_W-1:0]   dist_next;
    logic [SPEED_W-1:0]  speed_next;

    assign tick_now = vblnk_in && !vblnk_d_reg;
    assign in_race  = (state_reg == ST_RACE);

    speed_handshake #(
        .MAX_SPEED(MAX_SPEED)
    ) u_speed_handshake (
        .clk          (pclk),
        .rst          (rst),
        .tick         (tick_now),
        .in_race      (in_race),
        .speed_req    (speed_req),
        .speed_val    (speed_val),
        .crash_in     (crash_in),
        .speed_ack    (speed_ack),
        .spd_pend     (spd_pend),
        .pend_valid   (pend_valid),
        .crash_pending(crash_pending)
    );

    // Scroll and distance advance by the speed held before this tick's update.
    always_comb begin
        scroll_sum  = {1'b0, scroll_reg} + (VCOUNT_W + 1)'(speed_reg);
        scroll_next = (scroll_sum >= V_WRAP) ? VCOUNT_W'(scroll_sum - V_WRAP)
                                             : scroll_sum[VCOUNT_W-1:0];
        dist_sum    = {1'b0, dist_reg} + (DIST_W + 1)'(speed_reg);
        dist_next   = dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];
        speed_next  = speed_reg;
        if (crash_pending) begin
            speed_next = '0;
        end else if (pend_valid) begin
            speed_next = spd_pend;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_reg         <= ST_IDLE;
            vblnk_d_reg       <= 1'b0;
            tick_reg          <= 1'b0;
            digit_reg         <= 2'd0;
            cnt_reg           <= '0;
            scroll_reg        <= '0;
            dist_reg          <= '0;
            speed_reg         <= '0;
            start_pending_reg <= 1'b0;
            layer_reg         <= layer_for(ST_IDLE);
            done_reg          <= 1'b0;
        end else begin
            vblnk_d_reg <= vblnk_in;
            tick_reg    <= tick_now;
            if (state_reg == ST_IDLE && start_btn) begin
                start_pending_reg <= 1'b1;
            end
            if (tick_now) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_pending_reg) begin
                            state_reg         <= ST_COUNTDOWN;
                            digit_reg         <= 2'd3;
                            cnt_reg           <= '0;
                            speed_reg         <= '0;
                            dist_reg          <= '0;
                            scroll_reg        <= '0;
                            start_pending_reg <= 1'b0;
                            layer_reg         <= layer_for(ST_COUNTDOWN);
                            done_reg          <= 1'b0;
                        end
                    end
                    ST_COUNTDOWN: begin
                        if (cnt_reg == CD_LAST) begin
                            cnt_reg <= '0;
                            if (digit_reg == 2'd1) begin
                                state_reg <= ST_RACE;
                                digit_reg <= 2'd0;
                                layer_reg <= layer_for(ST_RACE);
                            end else begin
                                digit_reg <= digit_reg - 2'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    ST_RACE: begin
                        scroll_reg <= scroll_next;
                        dist_reg   <= dist_next;
                        speed_reg  <= speed_next;
                        if (dist_next >= TRACK_END) begin
                            state_reg <= ST_FINISH;
                            cnt_reg   <= '0;
                            layer_reg <= layer_for(ST_FINISH);
                            done_reg  <= 1'b1;
                        end
                    end
                    ST_FINISH: begin
                        if (cnt_reg == FIN_LAST) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                            layer_reg <= layer_for(ST_IDLE);
                            done_reg  <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign frame_tick = tick_reg;
    assign state      = state_reg;
    assign digit      = digit_reg;
    assign scroll_y   = scroll_reg;
    assign layer_en   = layer_reg;
    assign race_done  = done_reg;

endmodule

// File: tb/tb_race_frame_ctrl.sv
// Frame-by-frame directed test of race_frame_ctrl with small parameters so the
// countdown, wrap, saturation, crash and finish paths are all reached quickly.
module tb_race_frame_ctrl;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        start_btn = 1'b0;
    logic        crash_in = 1'b0;
    logic        speed_req = 1'b0;
    logic [3:0]  speed_val = 4'd0;
    logic        speed_ack;
    logic        frame_tick;
    logic [1:0]  state;
    logic [1:0]  digit;
    logic [10:0] scroll_y;
    logic [2:0]  layer_en;
    logic        race_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  s_state;
    logic [1:0]  s_digit;
    logic [10:0] s_scroll;
    logic [2:0]  s_layer;
    logic        s_done;

    typedef struct {
        bit          start;
        bit          req;
        logic [3:0]  rv;
        bit          req2;
        logic [3:0]  rv2;
        bit          crash;
        logic [1:0]  e_state;
        logic [1:0]  e_digit;
        logic [10:0] e_scroll;
        logic [2:0]  e_layer;
        bit          e_done;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    race_frame_ctrl #(
        .V_ACTIVE        (40),
        .COUNTDOWN_FRAMES(2),
        .TRACK_LEN       (100),
        .FINISH_FRAMES   (2),
        .MAX_SPEED       (10)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .start_btn (start_btn),
        .crash_in  (crash_in),
        .speed_req (speed_req),
        .speed_val (speed_val),
        .speed_ack (speed_ack),
        .frame_tick(frame_tick),
        .state     (state),
        .digit     (digit),
        .scroll_y  (scroll_y),
        .layer_en  (layer_en),
        .race_done (race_done)
    );

    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input int st, input int rq, input int rv, input int rq2,
                                input int rv2, input int cr, input int es, input int ed,
                                input int esc, input int el, input int edn);
        vec_t v;
        v.start    = (st != 0);
        v.req      = (rq != 0);
        v.rv       = 4'(rv);
        v.req2     = (rq2 != 0);
        v.rv2      = 4'(rv2);
        v.crash    = (cr != 0);
        v.e_state  = 2'(es);
        v.e_digit  = 2'(ed);
        v.e_scroll = 11'(esc);
        v.e_layer  = 3'(el);
        v.e_done   = (edn != 0);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic request(input int v);
        bit got;
        got = 1'b0;
        speed_req = 1'b1;
        speed_val = 4'(v);
        for (int k = 0; k < 8; k++) begin
            @(negedge pclk);
            if (speed_ack) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check("ack_seen", int'(got), 1);
        step();
        speed_req = 1'b0;
        @(negedge pclk);
        check("ack_width", int'(speed_ack), 0);
        step();
    endtask

    task automatic pulse_crash();
        crash_in = 1'b1;
        step();
        crash_in = 1'b0;
    endtask

    // Raise vblank, capture outputs on the frame_tick cycle, confirm the pulse is one cycle.
    task automatic do_tick();
        vblnk_in = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check("tick_hi", int'(frame_tick), 1);
        s_state  = state;
        s_digit  = digit;
        s_scroll = scroll_y;
        s_layer  = layer_en;
        s_done   = race_done;
        step();
        @(negedge pclk);
        check("tick_lo", int'(frame_tick), 0);
        step();
        vblnk_in = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_state",  int'(state), 0);
        check("rst_digit",  int'(digit), 0);
        check("rst_scroll", int'(scroll_y), 0);
        check("rst_layer",  int'(layer_en), 5);
        check("rst_done",   int'(race_done), 0);
        check("rst_ack",    int'(speed_ack), 0);
    endtask

    initial begin
        //            st rq rv rq2 rv2 cr | state digit scroll layer done
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,  1, 3,  0, 7, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0,  1, 3,  0, 7, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0,  1, 2,  0, 7, 0);
        tbl[3]  = mk(0, 1, 12, 0, 0, 0, 1, 2,  0, 7, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,  1, 1,  0, 7, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,  1, 1,  0, 7, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0,  2, 0,  0, 3, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,  2, 0,  0, 3, 0);
        tbl[8]  = mk(0, 1, 14, 0, 0, 0, 2, 0,  0, 3, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,  2, 0, 10, 3, 0);
        tbl[10] = mk(0, 1, 14, 1, 6, 0, 2, 0, 20, 3, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0,  2, 0, 26, 3, 0);
        tbl[12] = mk(0, 1, 10, 0, 0, 0, 2, 0, 32, 3, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0,  2, 0,  2, 3, 0);
        tbl[14] = mk(0, 1, 9, 0, 0, 1,  2, 0, 12, 3, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,  2, 0, 12, 3, 0);
        tbl[16] = mk(0, 1, 7, 0, 0, 0,  2, 0, 12, 3, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0,  2, 0, 19, 3, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0,  2, 0, 26, 3, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0,  2, 0, 33, 3, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0,  2, 0,  0, 3, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0,  2, 0,  7, 3, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 0,  2, 0, 14, 3, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 0,  3, 0, 21, 7, 1);
        tbl[24] = mk(1, 0, 0, 0, 0, 0,  3, 0, 21, 7, 1);
        tbl[25] = mk(1, 0, 0, 0, 0, 0,  0, 0, 21, 5, 0);
        tbl[26] = mk(0, 0, 0, 0, 0, 0,  0, 0, 21, 5, 0);
        tbl[27] = mk(1, 0, 0, 0, 0, 0,  1, 3,  0, 7, 0);

        // Power-up reset
        repeat (3) begin
            @(posedge pclk);
            @(negedge pclk);
            check("rst_no_tick", int'(frame_tick), 0);
        end
        check_reset_outputs();
        step();
        rst = 1'b1;
        idle(3);
        do_tick();
        check("first_state", int'(s_state), 0);
        check("first_layer", int'(s_layer), 5);
        $display("[TB] first frame state=%0d layer=%b", s_state, s_layer);

        for (int i = 0; i < NVEC; i++) begin
            idle(2);
            if (tbl[i].start) begin
                start_btn = 1'b1;
                idle(2);
                start_btn = 1'b0;
            end
            if (tbl[i].req)   request(int'(tbl[i].rv));
            if (tbl[i].req2)  request(int'(tbl[i].rv2));
            if (tbl[i].crash) pulse_crash();
            idle(2);
            do_tick();
            check("state",    int'(s_state),  int'(tbl[i].e_state));
            check("digit",    int'(s_digit),  int'(tbl[i].e_digit));
            check("scroll_y", int'(s_scroll), int'(tbl[i].e_scroll));
            check("layer_en", int'(s_layer),  int'(tbl[i].e_layer));
            check("race_done", int'(s_done),  int'(tbl[i].e_done));
            $display("[TB] frame %0d state=%0d digit=%0d scroll=%0d layer=%b done=%0d",
                     i, s_state, s_digit, s_scroll, s_layer, s_done);
        end

        // Mid-countdown reset during an active frame
        idle(2);
        rst = 1'b0;
        repeat (3) begin
            @(posedge pclk);
            @(negedge pclk);
            check("midrst_no_tick", int'(frame_tick), 0);
        end
        check_reset_outputs();
        step();
        rst = 1'b1;
        idle(2);
        do_tick();
        check("post_rst_state", int'(s_state), 0);
        check("post_rst_layer", int'(s_layer), 5);
        $display("[TB] after reset state=%0d layer=%b", s_state, s_layer);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
